factorial_engine: RTL and testbench
===================================

Name: factorial_engine

Overview:
Parametrised multi-cycle arithmetic sequence engine, the next generation of the combinational 4-bit-n / 32-bit-result function block.
- Computes n! (mode 0) or the triangular sum 1+2+..+n (mode 1) for an N_W-bit operand.
- Iterates one step per clock behind a start/busy/done handshake, with saturation and a sticky overflow flag.
- Sits between a control FSM issuing requests and a consumer register sampling result on done.

Parameters:
N_W, 4, operand width; n ranges 0..2^N_W-1.
RES_W, 32, result width; must be >= N_W+1 (elaboration-time check required).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only when busy=0.
n  input  N_W  operand, captured with start.
mode  input  1  0 = factorial, 1 = triangular sum; captured with start.
busy  output  1  high while a computation is in progress.
done  output  1  one-cycle pulse; result and overflow are valid and updated in that cycle.
result  output  RES_W  last completed value; held until the next completion.
overflow  output  1  last completion saturated; held with result.

Behaviour:
- Reset (asynchronous, immediate on rst_n low): state=IDLE, busy=0, done=0, result=0, overflow=0, internal acc/k/ovf cleared. Reset mid-computation aborts it with no done pulse.
- States are IDLE and CALC. Internal registers: n_q (N_W), mode_q, k (N_W+1 bits, so it cannot wrap at n=2^N_W-1), acc (RES_W), ovf_q.
- IDLE, edge with start=1:
  - capture n_q and mode_q;
  - k=1, acc=1 (mode 0) or 0 (mode 1), ovf_q=0;
  - go to CALC, busy=1.
- IDLE, start=0: no change. done is driven 0 in every cycle except the completion pulse.
- CALC, edge with k <= n_q:
  - mode 0: acc = acc*k, with the product formed at RES_W+N_W+1 bits.
  - mode 1: acc = acc+k, with the sum formed at RES_W+1 bits.
  - If the wide result exceeds 2^RES_W-1, or ovf_q is already 1: acc = all ones, ovf_q = 1 (saturating, sticky).
  - k = k+1.
- CALC, edge with k > n_q: result=acc, overflow=ovf_q, done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency: done rises on the (n+1)th rising edge after the edge that sampled start.
  - n=0 gives 1 cycle and returns 1 (mode 0) or 0 (mode 1).
  - busy is high for exactly n+1 cycles.
- start while busy=1 is ignored with no queuing. Changes to n or mode inputs during CALC have no effect.
- start asserted in the done cycle (state already IDLE) is accepted, giving back-to-back operation with no idle gap.
- Triangular sum cannot overflow when RES_W >= 2*N_W. Saturation logic must still be present for smaller RES_W.

Test Plan:
1. Reset/basic (defaults): pulse rst_n low for 10 ns, then start with n=5, mode=0 -> busy high 6 cycles; done on the 6th edge; result=120, overflow=0.
2. Boundaries: n=0, mode=0 -> done after 1 cycle, result=1. Then n=12 -> result=479001600 (0x1C8CFC00), overflow=0.
3. Overflow: n=13, mode=0 -> result=0xFFFFFFFF, overflow=1. Then n=15 -> still saturated. A following n=3 -> result=6, overflow=0 (flag cleared per request).
4. Sum mode: n=15, mode=1 -> done after 16 cycles, result=120. With n=1 -> result=1.
5. Handshake: start n=4 mode=0; during busy, pulse start with n=9 and toggle n and mode -> single done, result=24. start in the done cycle with n=3 -> next done 4 cycles later, result=6.
6. Reset mid-op and parameters: assert rst_n low during a CALC for n=10 -> no done; outputs read 0 immediately. Sweep n=0..15 in both modes and compare against a reference model. Repeat with N_W=3, RES_W=8: 5!=120 exact, 6! saturates to 0xFF with overflow=1.

Source files
------------

// File: rtl/factorial_engine.sv
// Multi-cycle sequence engine: n! (mode 0) or 1+2+..+n (mode 1), one step per clock,
// saturating at all ones with a sticky overflow flag, behind a start/busy/done handshake.
module factorial_engine #(
  parameter int N_W   = 4,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             overflow
);

  if (RES_W < N_W + 1) begin : g_bad_res_w
    $error("factorial_engine: RES_W must be at least N_W+1");
  end

  localparam int PW = RES_W + N_W + 1;
  localparam int SW = RES_W + 1;

  localparam logic [N_W:0]     K_ONE    = {{N_W{1'b0}}, 1'b1};
  localparam logic [RES_W-1:0] ACC_ZERO = {RES_W{1'b0}};
  localparam logic [RES_W-1:0] ACC_ONE  = {{(RES_W-1){1'b0}}, 1'b1};
  localparam logic [RES_W-1:0] ACC_SAT  = {RES_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [N_W-1:0]   n_q, n_d;
  logic             mode_q, mode_d;
  logic [N_W:0]     k_q, k_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;

  logic [PW-1:0]    prod_s;
  logic [SW-1:0]    sum_s;
  logic [RES_W-1:0] step_val_s;
  logic             step_ovf_s;
  logic             calc_done_s;

  // Wide step arithmetic so any excess above RES_W bits is visible for saturation.
  always_comb begin
    prod_s      = PW'(acc_q) * PW'(k_q);
    sum_s       = SW'(acc_q) + SW'(k_q);
    calc_done_s = (k_q > {1'b0, n_q});
    if (mode_q) begin
      step_val_s = sum_s[RES_W-1:0];
      step_ovf_s = sum_s[RES_W];
    end else begin
      step_val_s = prod_s[RES_W-1:0];
      step_ovf_s = |prod_s[PW-1:RES_W];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (calc_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CALC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath updates; inputs are only looked at in IDLE.
  always_comb begin
    n_d        = n_q;
    mode_d     = mode_q;
    k_d        = k_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d    = n;
          mode_d = mode;
          k_d    = K_ONE;
          acc_d  = mode ? ACC_ZERO : ACC_ONE;
          ovf_d  = 1'b0;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_CALC: begin
        if (calc_done_s) begin
          result_d   = acc_q;
          overflow_d = ovf_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
        end else begin
          // Sticky saturation: once overflowed, stay at all ones until the next request.
          if (step_ovf_s || ovf_q) begin
            acc_d = ACC_SAT;
            ovf_d = 1'b1;
          end else begin
            acc_d = step_val_s;
            ovf_d = 1'b0;
          end
          k_d    = k_q + K_ONE;
          busy_d = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= {N_W{1'b0}};
      mode_q     <= 1'b0;
      k_q        <= {(N_W+1){1'b0}};
      acc_q      <= ACC_ZERO;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= ACC_ZERO;
      overflow_q <= 1'b0;
    end else begin
      n_q        <= n_d;
      mode_q     <= mode_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_factorial_engine.sv
// Scoreboard bench for factorial_engine: a 4/32 instance and a 3/8 instance share one clock.
module tb_factorial_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start32, mode32;
  logic [3:0]  n32;
  logic        busy32, done32, ovf32;
  logic [31:0] res32;
  logic        start8, mode8;
  logic [2:0]  n8;
  logic        busy8, done8, ovf8;
  logic [7:0]  res8;

  always #5 clk = ~clk;

  factorial_engine #(.N_W(4), .RES_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .n(n32), .mode(mode32),
    .busy(busy32), .done(done32), .result(res32), .overflow(ovf32)
  );

  factorial_engine #(.N_W(3), .RES_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .n(n8), .mode(mode8),
    .busy(busy8), .done(done8), .result(res8), .overflow(ovf8)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          cyc;
    int          nb;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  int   run32 = 0;
  int   run8 = 0;

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // 32-bit monitor: pops on every done and checks value, flag, latency and busy length.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done32) begin
        if (q32.size() == 0) begin
          chk("unexpected_done32", 64'd1, 64'd0);
        end else begin
          e32 = q32.pop_front();
          chk("result32", {32'd0, res32}, {32'd0, e32.res});
          chk("overflow32", {63'd0, ovf32}, {63'd0, e32.ovf});
          chk("latency32", 64'(cyc_cnt), 64'(e32.cyc));
          chk("busy_len32", 64'(run32), 64'(e32.nb));
        end
        run32 = 0;
      end else if (busy32) begin
        run32++;
      end else begin
        run32 = 0;
      end
    end else begin
      run32 = 0;
    end
  end

  // 8-bit monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done8) begin
        if (q8.size() == 0) begin
          chk("unexpected_done8", 64'd1, 64'd0);
        end else begin
          e8 = q8.pop_front();
          chk("result8", {56'd0, res8}, {32'd0, e8.res});
          chk("overflow8", {63'd0, ovf8}, {63'd0, e8.ovf});
          chk("latency8", 64'(cyc_cnt), 64'(e8.cyc));
          chk("busy_len8", 64'(run8), 64'(e8.nb));
        end
        run8 = 0;
      end else if (busy8) begin
        run8++;
      end else begin
        run8 = 0;
      end
    end else begin
      run8 = 0;
    end
  end

  // Waits for the selected engine to be idle at a falling edge, then raises start for one cycle.
  task automatic issue(input bit sel, input int nv, input bit md,
                       input logic [31:0] er, input bit eo, input bit push);
    int   w = 0;
    exp_t e;
    do begin
      @(negedge clk);
      w++;
    end while ((sel ? busy8 : busy32) && w < 300);
    if (w >= 300) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: engine %0d still busy after %0d cycles", sel, w);
    end
    e.res = er;
    e.ovf = eo;
    e.cyc = cyc_cnt + 1 + nv + 1;
    e.nb  = nv + 1;
    if (sel) begin
      start8 = 1'b1; n8 = nv[2:0]; mode8 = md;
      if (push) q8.push_back(e);
    end else begin
      start32 = 1'b1; n32 = nv[3:0]; mode32 = md;
      if (push) q32.push_back(e);
    end
    @(negedge clk);
    start32 = 1'b0;
    start8  = 1'b0;
  endtask

  function automatic void ref_model(input int resw, input int nv, input bit md,
                                    output logic [31:0] r, output bit o);
    logic [63:0] acc;
    logic [63:0] mx;
    mx  = (64'd1 << resw) - 64'd1;
    acc = md ? 64'd0 : 64'd1;
    o   = 1'b0;
    for (int k = 1; k <= nv; k++) begin
      acc = md ? acc + 64'(k) : acc * 64'(k);
      if (acc > mx || o) begin
        acc = mx;
        o   = 1'b1;
      end
    end
    r = acc[31:0];
  endfunction

  initial begin
    logic [31:0] r;
    bit          o;
    int          w;
    rst_n = 1'b0;
    start32 = 1'b0; n32 = 4'd0; mode32 = 1'b0;
    start8  = 1'b0; n8  = 3'd0; mode8  = 1'b0;
    #10 rst_n = 1'b1;
    #1;
    chk("reset_busy", {63'd0, busy32}, 64'd0);
    chk("reset_done", {63'd0, done32}, 64'd0);
    chk("reset_result", {32'd0, res32}, 64'd0);
    chk("reset_overflow", {63'd0, ovf32}, 64'd0);
    chk("reset_result8", {56'd0, res8}, 64'd0);

    // Basic, boundaries, overflow, sum mode
    issue(1'b0, 5, 1'b0, 32'd120, 1'b0, 1'b1);
    issue(1'b0, 0, 1'b0, 32'd1, 1'b0, 1'b1);
    issue(1'b0, 12, 1'b0, 32'h1C8CFC00, 1'b0, 1'b1);
    issue(1'b0, 13, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1);
    issue(1'b0, 15, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1);
    issue(1'b0, 3, 1'b0, 32'd6, 1'b0, 1'b1);
    issue(1'b0, 15, 1'b1, 32'd120, 1'b0, 1'b1);
    issue(1'b0, 1, 1'b1, 32'd1, 1'b0, 1'b1);
    issue(1'b0, 0, 1'b1, 32'd0, 1'b0, 1'b1);

    // Handshake: start and input changes while busy are ignored
    repeat (3) @(negedge clk);
    issue(1'b0, 4, 1'b0, 32'd24, 1'b0, 1'b1);
    start32 = 1'b1; n32 = 4'd9; mode32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; n32 = 4'd7; mode32 = 1'b0;
    @(negedge clk);
    n32 = 4'd2; mode32 = 1'b1;
    issue(1'b0, 3, 1'b0, 32'd6, 1'b0, 1'b1);

    // Reset in the middle of a computation: no done, outputs cleared at once
    issue(1'b0, 10, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", {63'd0, busy32}, 64'd0);
    chk("midreset_done", {63'd0, done32}, 64'd0);
    chk("midreset_result", {32'd0, res32}, 64'd0);
    chk("midreset_overflow", {63'd0, ovf32}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // Sweep against the reference model
    for (int md = 0; md < 2; md++) begin
      for (int nv = 0; nv < 16; nv++) begin
        ref_model(32, nv, md[0], r, o);
        issue(1'b0, nv, md[0], r, o, 1'b1);
      end
    end

    // Narrow instance
    issue(1'b1, 5, 1'b0, 32'd120, 1'b0, 1'b1);
    issue(1'b1, 6, 1'b0, 32'hFF, 1'b1, 1'b1);
    issue(1'b1, 7, 1'b1, 32'd28, 1'b0, 1'b1);
    issue(1'b1, 0, 1'b0, 32'd1, 1'b0, 1'b1);

    w = 0;
    while ((q32.size() != 0 || q8.size() != 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    #1;
    chk("drain_queues", 64'(q32.size() + q8.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
